// File: rtl/pc_request_unit_pkg.sv
// Shared CPU types: PC select encoding from the control unit, the request
// FSM states and the fixed PC increment.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    NEXT         = 3'd0,
    BRANCH       = 3'd1,
    JUMP         = 3'd2,
    JUMPREGISTER = 3'd3,
    PC_HALT      = 3'd4
  } pcselect_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_request_unit_if.sv
// Control-unit / memory-side signals of the PC request unit; slave is the
// unit itself, master is whatever drives it.
interface pc_request_unit_if;
  import cpu_types_pkg::*;

  pcselect_t   pc_select;
  logic [31:0] jump_data;
  logic [31:0] immediate;
  logic [31:0] rdat1;
  logic        dREN;
  logic        dWEN;
  logic        cpu_halt;
  logic        ihit;
  logic        dhit;
  logic [31:0] imemaddr;
  logic        imemREN;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] rtn_addr;
  logic        halt;
  logic        misalign;

  modport slave (
    input  pc_select, jump_data, immediate, rdat1, dREN, dWEN, cpu_halt, ihit, dhit,
    output imemaddr, imemREN, dmemREN, dmemWEN, rtn_addr, halt, misalign
  );

  modport master (
    output pc_select, jump_data, immediate, rdat1, dREN, dWEN, cpu_halt, ihit, dhit,
    input  imemaddr, imemREN, dmemREN, dmemWEN, rtn_addr, halt, misalign
  );
endinterface

// File: rtl/pc_request_unit_next_pc.sv
// Combinational next-PC selection: sequential, branch, jump and jump-register
// targets. Macro PC_MISALIGN_CHECK_EN keeps the raw JR target (caller traps).
module next_pc
  import cpu_types_pkg::*;
(
  input  logic [31:0]        i_pc,
  input  pcselect_t          i_sel,
  input  logic [25:0]        i_jump_target,
  input  logic signed [31:0] i_immediate,
  input  logic [31:0]        i_rdat1,
  output logic [31:0]        o_pc_plus4,
  output logic [31:0]        o_next_pc
);

  logic signed [31:0] w_branch_off;
  logic [31:0]        w_jr_target;

  assign o_pc_plus4   = i_pc + PC_STEP;
  assign w_branch_off = i_immediate <<< 2;

`ifdef PC_MISALIGN_CHECK_EN
  assign w_jr_target = i_rdat1;
`else
  assign w_jr_target = {i_rdat1[31:2], 2'b00};
`endif

  always_comb begin
    o_next_pc = o_pc_plus4;
    case (i_sel)
      BRANCH:       o_next_pc = o_pc_plus4 + $unsigned(w_branch_off);
      JUMP:         o_next_pc = {o_pc_plus4[31:28], i_jump_target, 2'b00};
      JUMPREGISTER: o_next_pc = w_jr_target;
      default:      o_next_pc = o_pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_request_unit.sv
// Program counter and instruction/data request sequencer for the single-cycle
// core. Optional macro PC_MISALIGN_CHECK_EN traps misaligned JR targets.
module pc_request_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              nRST,
  pc_request_unit_if.slave  bus
);

  reqstate_t   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_dmemREN, w_dmemREN_nxt;
  logic        r_dmemWEN, w_dmemWEN_nxt;
  logic        r_misalign, w_misalign_nxt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_jr_misaligned;

  next_pc u_next_pc (
    .i_pc          (r_pc),
    .i_sel         (bus.pc_select),
    .i_jump_target (bus.jump_data[25:0]),
    .i_immediate   (bus.immediate),
    .i_rdat1       (bus.rdat1),
    .o_pc_plus4    (w_pc_plus4),
    .o_next_pc     (w_target)
  );

`ifdef PC_MISALIGN_CHECK_EN
  assign w_jr_misaligned = (bus.pc_select == JUMPREGISTER) && (bus.rdat1[1:0] != 2'b00);
`else
  assign w_jr_misaligned = 1'b0;
`endif

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_state    <= FETCH;
      r_pc       <= PC_INIT;
      r_dmemREN  <= 1'b0;
      r_dmemWEN  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_dmemREN  <= w_dmemREN_nxt;
      r_dmemWEN  <= w_dmemWEN_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  // PC only moves on the hit that retires the instruction.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_dmemREN_nxt  = r_dmemREN;
    w_dmemWEN_nxt  = r_dmemWEN;
    w_misalign_nxt = r_misalign;
    case (r_state)
      FETCH: begin
        if (bus.ihit) begin
          if (bus.cpu_halt || (bus.pc_select == PC_HALT)) begin
            w_state_nxt = HALTED;
          end else if (w_jr_misaligned) begin
            w_state_nxt    = HALTED;
            w_misalign_nxt = 1'b1;
          end else if (bus.dREN || bus.dWEN) begin
            w_state_nxt   = DATA;
            w_dmemREN_nxt = bus.dREN;
            w_dmemWEN_nxt = bus.dWEN;
          end else begin
            w_pc_nxt = w_target;
          end
        end
      end
      DATA: begin
        if (bus.dhit) begin
          w_state_nxt   = FETCH;
          w_dmemREN_nxt = 1'b0;
          w_dmemWEN_nxt = 1'b0;
          w_pc_nxt      = w_pc_plus4;
        end
      end
      default: begin
        w_state_nxt = HALTED;
      end
    endcase
  end

  assign bus.imemaddr = r_pc;
  assign bus.rtn_addr = w_pc_plus4;
  assign bus.imemREN  = (r_state == FETCH) && !nRST;
  assign bus.dmemREN  = r_dmemREN;
  assign bus.dmemWEN  = r_dmemWEN;
  assign bus.halt     = (r_state == HALTED);
`ifdef PC_MISALIGN_CHECK_EN
  assign bus.misalign = r_misalign;
`else
  assign bus.misalign = 1'b0;
`endif

endmodule

// File: doc/pc_request_unit.md
# pc_request_unit

Holds the program counter and sequences instruction and data memory requests for the single-cycle MIPS core. Sits directly downstream of the control unit: it consumes `pc_select`, `jump_data`, `immediate`, `dREN`, `dWEN` and `cpu_halt` and produces the fetch address, memory request strobes, return address and sticky halt. The PC advances exactly once per retired instruction, after the instruction hit and, for loads and stores, after the data hit.

## Interface
- `PC_INIT`, default 32'h0000_0000, PC value loaded on reset.
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous reset, active-high (1 = reset asserted).
- `pc_select` in pcselect_t: NEXT / BRANCH / JUMP / JUMPREGISTER / PC_HALT from the control unit.
- `jump_data` in 32: current instruction word; bits [25:0] are the jump target.
- `immediate` in 32: sign-extended branch offset in words.
- `rdat1` in 32: register rs, used as the JR target.
- `dREN`, `dWEN` in 1: the current instruction is a load / store.
- `cpu_halt` in 1: the current instruction is HALT.
- `ihit`, `dhit` in 1: instruction / data memory request complete this cycle.
- `imemaddr` out 32: current PC.
- `imemREN` out 1: instruction read request.
- `dmemREN`, `dmemWEN` out 1: registered data read / write request.
- `rtn_addr` out 32: PC+4, used by JAL writeback.
- `halt` out 1: sticky halt.
- `misalign` out 1: sticky misaligned-JR flag.

## Operation
- FSM states: FETCH (reset state), DATA, HALTED.
- **FETCH**
  - `imemREN`=1.
  - On `ihit` with `cpu_halt` or `pc_select`==PC_HALT: go to HALTED; PC holds.
  - On `ihit` with `dREN|dWEN`: register `dmemREN<=dREN` and `dmemWEN<=dWEN`; go to DATA; PC holds.
  - On `ihit` otherwise: PC <= next PC; stay in FETCH.
  - `dhit` is ignored in FETCH.
- **DATA**
  - `imemREN`=0; PC holds.
  - On `dhit`: clear `dmemREN` and `dmemWEN`, PC <= PC+4, go to FETCH.
  - `ihit` is ignored in DATA.
- **HALTED**: absorbing until reset. `halt`=1. All request outputs are 0. PC is frozen.
- **Next PC** (32-bit, wrap modulo 2^32):
  - NEXT: PC+4.
  - BRANCH: PC+4+(immediate<<2).
  - JUMP: {PC+4[31:28], jump_data[25:0], 2'b00}.
  - JUMPREGISTER: rdat1.
- `rtn_addr` = PC+4 at all times. It is combinational from the PC register.

## Timing
- Non-memory instruction: PC updates on the edge where `ihit`=1, so 1 cycle minimum.
- Load/store: `dmemREN`/`dmemWEN` rise on the `ihit` edge and fall on the `dhit` edge. PC updates on the `dhit` edge, so 2 cycles minimum.
- Inputs from the control unit must be stable while in DATA. This holds because the PC, and therefore `imemload`, is held.
- **Reset** (asynchronous, any state, including mid-DATA):
  - state=FETCH, PC=`PC_INIT`.
  - `dmemREN`=`dmemWEN`=`halt`=`misalign`=0.
  - `imemREN` is forced 0 while `nRST`=1 and goes to 1 in the first cycle after release.
  - `rtn_addr`=`PC_INIT`+4.
- PC wraps: 32'hFFFF_FFFC + 4 gives 0 with no flag.

## Configuration
- `PC_MISALIGN_CHECK_EN` defined: on `ihit` in FETCH with `pc_select`==JUMPREGISTER and `rdat1[1:0]`!=0:
  - go to HALTED, set `misalign`=1 and `halt`=1;
  - PC holds.
- `PC_MISALIGN_CHECK_EN` undefined: the JR target is `{rdat1[31:2], 2'b00}` and `misalign` is tied 0. The port exists in both builds.

## Structure
- `cpu_types_pkg`:
  - pcselect_t, already shared with the control unit.
  - New reqstate_t enum {FETCH, DATA, HALTED}.
  - Constant PC_STEP = 32'd4.
- One combinational sub-module, `next_pc`, computes the four targets and the select. The FSM and the PC register stay in the top.

## Test plan
- **Sequential fetch**: reset, `PC_INIT`=0, NEXT with `ihit`=1 for 3 cycles -> `imemaddr` 0, 4, 8, 12; `rtn_addr` 4, 8, 12, 16.
- **Load with wait**: PC=0x10, `dREN`=1, `ihit` -> `dmemREN`=1, PC=0x10. Hold `dhit`=0 for 3 cycles -> unchanged. Then `dhit` -> `dmemREN`=0, PC=0x14, FETCH.
- **Branch and jump**:
  - PC=0x20, BRANCH, `immediate`=0xFFFF_FFFE -> PC=0x1C.
  - PC=0x1C, JUMP, `jump_data`[25:0]=0x40 -> PC=0x100.
  - JUMPREGISTER, `rdat1`=0x200 -> PC=0x200.
- **Halt**: HALT with `ihit` -> `halt`=1, `imemREN`=0. Later `ihit`/`dhit` pulses leave PC and outputs unchanged.
- **Reset mid-DATA**: assert `nRST` while `dmemWEN`=1 -> `dmemWEN`=0 and PC=`PC_INIT` immediately, before the next edge. `imemREN`=1 one cycle after release.
- **Misaligned JR**: `rdat1`=0x203.
  - With the macro: `misalign`=1, `halt`=1, PC held.
  - Without the macro: PC=0x200, `misalign`=0.
